sram_array: RTL and testbench
=============================

# sram_array

Parametrised, synchronous SRAM macro model built from rows of write-enabled bitcells. It keeps the bitcell's `r_w`/`sel` access style (r_w = 1 write, r_w = 0 read) and generalises it from one bit to a WIDTH × DEPTH array. It adds a clocked precharge/access sequence, a ready/valid handshake and captured request operands. It sits between the memory controller and the datapath as the team's first multi-word storage block.

## Interface
- `WIDTH`, default 8: data word width in bits (≥1).
- `DEPTH`, default 16: number of words (≥2; need not be a power of two).
- `ADDR_W`, default $clog2(DEPTH): address width (derived; do not override).

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `sel`  in  1  request valid.
- `r_w`  in  1  operation: 1 = write, 0 = read.
- `addr`  in  ADDR_W  word address.
- `in`  in  WIDTH  write data.
- `wmask`  in  WIDTH  per-bit write enable (present only with SRAM_BITMASK_EN).
- `ready`  out  1  block can accept a request.
- `out`  out  WIDTH  read data; all-ones (precharged) when not holding read data.
- `out_valid`  out  1  one-cycle pulse: `out` carries the result of a read.

## Operation
- Reset values: `ready` = 1, `out` = all-ones, `out_valid` = 0, all array words = 0, FSM = IDLE.
- FSM states:
  - IDLE: `ready` = 1. `sel && ready` at a rising edge accepts the request and captures `r_w`, `addr`, `in` and `wmask`. Next state is PRE.
  - PRE (1 cycle): `ready` = 0 and `out` is forced to all-ones. Next state is ACC.
  - ACC (1 cycle): `ready` = 0.
    - Write: the array word is updated at the edge that leaves ACC.
    - Read: at that same edge `out` loads the stored word and `out_valid` is set for one cycle.
    - Next state is IDLE.
- Request inputs are sampled only at acceptance. Changes to them in PRE or ACC are ignored.
- `sel` while `ready` = 0 is ignored. There is no queueing; the requester must hold `sel` until it sees `ready`.
- `out` holds the last read data until the next accepted request enters PRE, including across writes issued in the meantime.
- Out-of-range address (`addr` ≥ DEPTH):
  - Write is dropped and no word changes.
  - Read returns all-zeros with the normal `out_valid` pulse.
- Read after write to the same address returns the new data, because the write committed before the read's PRE.
- Reset asserted mid-operation aborts the request immediately:
  - An in-flight write is not committed.
  - No `out_valid` pulse is produced.
  - The array is cleared.

## Timing
- Request accepted at edge N.
- PRE occupies the cycle after edge N; ACC occupies the cycle after edge N+1.
- Write data is visible in the array after edge N+2.
- Read: `out` and `out_valid` are valid in the cycle after edge N+2, so read latency = 3 edges.
- `ready` is low from edge N to edge N+2 and high again after edge N+2.
- Maximum throughput: one request every 3 cycles (back-to-back acceptance at N, N+3, …).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SRAM_BITMASK_EN` defined:
  - The `wmask` port exists.
  - Writes update only the bits where the captured `wmask` = 1; all other bits keep their stored value.
  - Reads are unaffected.
- `SRAM_BITMASK_EN` undefined:
  - There is no `wmask` port.
  - Every write replaces the full word.

## Structure
- Package `sram_pkg` holds:
  - the state enum {IDLE, PRE, ACC} (2 bits);
  - localparam `PRECHARGE_VAL` = all-ones pattern;
  - localparam `OOR_READ_VAL` = all-zeros.
- Sub-module `sram_word`: one row of WIDTH storage bits with asynchronous clear, row enable and bit-mask write. It is instantiated DEPTH times via generate. The top level holds the FSM, request capture, address decode and read mux.

## Test plan
- Reset, then write 0xA5 to addr 3, then read addr 3 → `out_valid` pulse 3 edges after read acceptance, `out` = 0xA5; `out` = 0xFF during PRE.
- After reset, read addr 7 → `out` = 0x00; hold `sel` high for 6 cycles → exactly 2 requests accepted, at N and N+3.
- DEPTH = 10: write 0x3C to addr 12, then read addr 12 → `out` = 0x00; a sweep of reads over addrs 0–9 returns 0x00 (no word corrupted).
- Write 0x11 to addr 5, assert `rst` in that write's PRE cycle, then read addr 5 → `out` = 0x00, with no `out_valid` pulse during reset.
- With SRAM_BITMASK_EN: write 0xFF to addr 2, then write `in` = 0x00 with `wmask` = 0x0F, then read addr 2 → 0xF0. Without the macro, the same sequence (no mask) → 0x00.
- Change `addr`/`in` during PRE of a write to addr 1 with data 0x42 → readback of addr 1 = 0x42; the addr driven during PRE is unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg -- shared types and constants for the sram_array block.
//
// Contents:
//   state_t        access sequencer states {IDLE, PRE, ACC}, 2-bit encoding
//   PRECHARGE_VAL  per-bit value of the precharged read bus (all-ones word)
//   OOR_READ_VAL   per-bit value returned for an out-of-range read (all-zeros word)
//
// The two constants are single bits because WIDTH is a parameter of the
// users.  A word-wide pattern is built by replication, e.g.
// {WIDTH{PRECHARGE_VAL}}.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ACC  = 2'd2
    } state_t;

    localparam logic PRECHARGE_VAL = 1'b1;
    localparam logic OOR_READ_VAL  = 1'b0;

endpackage

// File: rtl/sram_word.sv
// sram_word -- one row of WIDTH bitcells.
//
// Each bitcell is a flop with an asynchronous clear.  A bit is written on
// the rising clock edge only when the row is enabled and its mask bit is set.
// With a full-ones mask the row behaves as a plain word register.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high clear, all bits go to 0
//   row_en  in   row selected for a write this cycle
//   wmask   in   [WIDTH] per-bit write enable
//   wdata   in   [WIDTH] write data
//   q       out  [WIDTH] stored word
module sram_word #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             row_en,
    input  logic [WIDTH-1:0] wmask,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            logic bit_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bit_reg <= 1'b0;
                end else if (row_en && wmask[gi]) begin
                    bit_reg <= wdata[gi];
                end
            end

            assign q[gi] = bit_reg;
        end
    endgenerate

endmodule

// File: rtl/sram_array.sv
// sram_array -- synchronous WIDTH x DEPTH SRAM macro model.
//
// A request is accepted when sel is high in IDLE (ready = 1).  The block then
// runs a fixed PRE -> ACC sequence.  In PRE the read bus is precharged to
// all-ones.  On the edge that leaves ACC, a write commits to the addressed row
// or a read loads out and pulses out_valid.  Throughput is one request every
// three cycles.  Addresses >= DEPTH drop writes and read back all-zeros.
//
// Optional feature (macro SRAM_BITMASK_EN):
//   defined   -> the wmask port exists and writes touch only the bits with mask = 1
//   undefined -> no wmask port and writes replace the whole word
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset; aborts any request and clears the array
//   sel        in   request valid
//   r_w        in   1 = write, 0 = read
//   addr       in   [ADDR_W] word address
//   in         in   [WIDTH] write data
//   wmask      in   [WIDTH] per-bit write enable (SRAM_BITMASK_EN only)
//   ready      out  block can accept a request
//   out        out  [WIDTH] read data, all-ones when not holding read data
//   out_valid  out  one-cycle pulse marking read data on out
module sram_array
    import sram_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              r_w,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  in,
`ifdef SRAM_BITMASK_EN
    input  logic [WIDTH-1:0]  wmask,
`endif
    output logic              ready,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid
);

    state_t             state_reg;
    logic               r_w_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [WIDTH-1:0]   in_reg;
    logic [WIDTH-1:0]   wmask_reg;
    logic               ready_reg;
    logic [WIDTH-1:0]   out_reg;
    logic               out_valid_reg;

    logic [WIDTH-1:0]   word_q [DEPTH];
    logic [DEPTH-1:0]   row_en;
    logic [WIDTH-1:0]   rd_data;
    logic               commit_write;

    // Writes land on the edge that leaves ACC.  An out-of-range address
    // matches no row, so the write is simply dropped.
    assign commit_write = (state_reg == ACC) && r_w_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_row
            assign row_en[gi] = commit_write && (addr_reg == ADDR_W'(gi));

            sram_word #(
                .WIDTH (WIDTH)
            ) u_word (
                .clk    (clk),
                .rst    (rst),
                .row_en (row_en[gi]),
                .wmask  (wmask_reg),
                .wdata  (in_reg),
                .q      (word_q[gi])
            );
        end
    endgenerate

    // Read mux.  It defaults to the out-of-range value so that addresses
    // beyond DEPTH, which can occur when DEPTH is not a power of two,
    // read back as zeros.
    always_comb begin
        rd_data = {WIDTH{OOR_READ_VAL}};
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_reg == ADDR_W'(i)) begin
                rd_data = word_q[i];
            end
        end
    end

    // Access sequencer.  All outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            r_w_reg       <= 1'b0;
            addr_reg      <= '0;
            in_reg        <= '0;
            wmask_reg     <= '0;
            ready_reg     <= 1'b1;
            out_reg       <= {WIDTH{PRECHARGE_VAL}};
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (sel) begin
                        // Operands are frozen here.  Input changes during
                        // PRE and ACC are ignored.
                        r_w_reg   <= r_w;
                        addr_reg  <= addr;
                        in_reg    <= in;
`ifdef SRAM_BITMASK_EN
                        wmask_reg <= wmask;
`else
                        wmask_reg <= '1;
`endif
                        ready_reg <= 1'b0;
                        // Precharge the bus as the request enters PRE.  Any
                        // previously held read data is released at this point.
                        out_reg   <= {WIDTH{PRECHARGE_VAL}};
                        state_reg <= PRE;
                    end
                end
                PRE: begin
                    state_reg <= ACC;
                end
                ACC: begin
                    if (!r_w_reg) begin
                        out_reg       <= rd_data;
                        out_valid_reg <= 1'b1;
                    end
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_reg;
    assign out       = out_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_sram_array.sv
// tb_sram_array -- self-checking bench for sram_array (WIDTH = 8, DEPTH = 10).
//
// Directed scenarios run first, followed by randomized transactions.  Each
// transaction is checked against a plain array model of the memory contents.
// The optional write mask is exercised when SRAM_BITMASK_EN is defined.
module tb_sram_array;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 10;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk;
    logic              rst;
    logic              sel;
    logic              r_w;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  in;
    logic [WIDTH-1:0]  wmask;
    logic              ready;
    logic [WIDTH-1:0]  out;
    logic              out_valid;

    int compared   = 0;
    int mismatched = 0;

    logic [WIDTH-1:0] mem_model [DEPTH];

    sram_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .r_w       (r_w),
        .addr      (addr),
        .in        (in),
`ifdef SRAM_BITMASK_EN
        .wmask     (wmask),
`endif
        .ready     (ready),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    endtask

    // Reference behaviour: masked write into an array, or a read with an
    // all-zeros result for addresses outside the array.
    function automatic logic [WIDTH-1:0] model_read(input int a);
        return (a < DEPTH) ? mem_model[a] : '0;
    endfunction

    task automatic model_write(input int a, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
        logic [WIDTH-1:0] eff_m;
`ifdef SRAM_BITMASK_EN
        eff_m = m;
`else
        eff_m = '1;
`endif
        if (a < DEPTH) mem_model[a] = (mem_model[a] & ~eff_m) | (d & eff_m);
    endtask

    // One full transaction.  The task is entered and left on a negedge.
    // When scramble is set, the request inputs are changed during PRE
    // (sel is held high as well) to show that they are ignored.
    task automatic do_req(input logic rw, input int a, input logic [WIDTH-1:0] d,
                          input logic [WIDTH-1:0] m, input bit scramble);
        logic [WIDTH-1:0] exp_rd;
        sel   = 1'b1;
        r_w   = rw;
        addr  = ADDR_W'(a);
        in    = d;
        wmask = m;
        check("idle_ready", ready, 1);
        @(posedge clk); @(negedge clk);            // PRE
        if (scramble) begin
            r_w   = ~rw;
            addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            in    = WIDTH'($urandom);
            wmask = WIDTH'($urandom);
        end else begin
            sel = 1'b0;
        end
        check("pre_ready", ready, 0);
        check("pre_out", out, 32'hFF);
        check("pre_valid", out_valid, 0);
        @(posedge clk); @(negedge clk);            // ACC
        sel = 1'b0;
        check("acc_ready", ready, 0);
        check("acc_valid", out_valid, 0);
        @(posedge clk); @(negedge clk);            // back in IDLE
        check("done_ready", ready, 1);
        if (rw) begin
            model_write(a, d, m);
            check("wr_valid", out_valid, 0);
            check("wr_out", out, 32'hFF);
            $display("txn WR addr=%0d data=%02h mask=%02h", a, d, m);
        end else begin
            exp_rd = model_read(a);
            check("rd_valid", out_valid, 1);
            check("rd_data", out, exp_rd);
            $display("txn RD addr=%0d data=%02h exp=%02h", a, out, exp_rd);
        end
    endtask

    initial begin
        int acc_mask;
        int pulses;
        logic [WIDTH-1:0] exp_mask_rd;

        rst = 1'b1; sel = 1'b0; r_w = 1'b0; addr = '0; in = '0; wmask = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_out", out, 32'hFF);
        check("rst_valid", out_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // Write then read back one word.
        do_req(1'b1, 3, 8'hA5, 8'hFF, 1'b0);
        do_req(1'b0, 3, 8'h00, 8'h00, 1'b0);
        check("a5_readback", out, 32'hA5);

        // Hold sel across 6 edges.  Two acceptances are expected, at
        // offsets 0 and 3, each followed by a read pulse returning zero.
        sel = 1'b1; r_w = 1'b0; addr = ADDR_W'(7);
        acc_mask = 0; pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (ready) acc_mask |= (1 << c);
            @(posedge clk); @(negedge clk);
            if (out_valid) begin
                pulses++;
                check("held_rd_data", out, 32'h00);
            end
        end
        sel = 1'b0;
        check("held_accept_slots", acc_mask, 9);
        check("held_pulses", pulses, 2);
        $display("txn HELD-SEL accept_mask=%0h pulses=%0d", acc_mask, pulses);

        // Out-of-range write is dropped and the read returns zeros.
        do_req(1'b1, 12, 8'h3C, 8'hFF, 1'b0);
        do_req(1'b0, 12, 8'h00, 8'h00, 1'b0);
        for (int a = 0; a < DEPTH; a++) do_req(1'b0, a, 8'h00, 8'h00, 1'b0);

        // Reset during a write's PRE cycle aborts it and clears the array.
        sel = 1'b1; r_w = 1'b1; addr = ADDR_W'(5); in = 8'h11; wmask = 8'hFF;
        @(posedge clk); @(negedge clk);
        sel = 1'b0;
        rst = 1'b1;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            #1 check("rstmid_valid", out_valid, 0);
            check("rstmid_ready", ready, 1);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("txn RESET mid-write addr=5");
        do_req(1'b0, 5, 8'h00, 8'h00, 1'b0);
        check("rst_abort_data", out, 32'h00);
        do_req(1'b0, 3, 8'h00, 8'h00, 1'b0);

        // Bit-mask write.  Without the mask feature the second write replaces
        // the whole word.
        do_req(1'b1, 2, 8'hFF, 8'hFF, 1'b0);
        do_req(1'b1, 2, 8'h00, 8'h0F, 1'b0);
        do_req(1'b0, 2, 8'h00, 8'h00, 1'b0);
`ifdef SRAM_BITMASK_EN
        exp_mask_rd = 8'hF0;
`else
        exp_mask_rd = 8'h00;
`endif
        check("mask_readback", out, exp_mask_rd);

        // Input changes during PRE must not alter the captured request.
        do_req(1'b1, 4, 8'h77, 8'hFF, 1'b0);
        do_req(1'b1, 1, 8'h42, 8'hFF, 1'b1);
        do_req(1'b0, 1, 8'h00, 8'h00, 1'b0);
        check("capture_data", out, 32'h42);
        do_req(1'b0, 4, 8'h00, 8'h00, 1'b0);

        // Randomized traffic, including out-of-range addresses and scrambling.
        for (int t = 0; t < 60; t++) begin
            do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
                   WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int a = 0; a < DEPTH; a++) do_req(1'b0, a, 8'h00, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
